// File: rtl/winner_merge_2to1_if.sv
// Handshake bundle for winner_merge_2to1: winner IDs, two data channels, output link.
// out_data widens by one tag bit when WINNER_MERGE_SRC_TAG_EN is defined.
interface winner_merge_2to1_if #(
  parameter int WIDTH = 33
);
`ifdef WINNER_MERGE_SRC_TAG_EN
  localparam int OW = WIDTH + 1;
`else
  localparam int OW = WIDTH;
`endif

  logic             win_valid;
  logic             win_id;
  logic             win_ready;
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;
  logic             out_valid;
  logic [OW-1:0]    out_data;
  logic             out_ready;
  logic             idle;

  modport master (
    output win_valid, win_id,
    output in0_valid, in0_data,
    output in1_valid, in1_data,
    output out_ready,
    input  win_ready, in0_ready, in1_ready,
    input  out_valid, out_data, idle
  );

  modport slave (
    input  win_valid, win_id,
    input  in0_valid, in0_data,
    input  in1_valid, in1_data,
    input  out_ready,
    output win_ready, in0_ready, in1_ready,
    output out_valid, out_data, idle
  );
endinterface

// File: rtl/winner_merge_2to1.sv
// Merges two channels onto one link in arbiter winner-ID order via grant/output FIFOs.
// Optional WINNER_MERGE_SRC_TAG_EN appends the source channel ID as out_data[WIDTH].
module winner_merge_2to1 #(
  parameter int WIDTH     = 33,
  parameter int GNT_DEPTH = 2,
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  winner_merge_2to1_if.slave bus
);
  localparam int GA = $clog2(GNT_DEPTH);
  localparam int OA = $clog2(OUT_DEPTH);
`ifdef WINNER_MERGE_SRC_TAG_EN
  localparam int OW = WIDTH + 1;
`else
  localparam int OW = WIDTH;
`endif
  localparam logic [GA:0] GFULL = (GA+1)'(GNT_DEPTH);
  localparam logic [OA:0] OFULL = (OA+1)'(OUT_DEPTH);

  logic          gnt_mem [GNT_DEPTH];
  logic [GA-1:0] gnt_wp;
  logic [GA-1:0] gnt_rp;
  logic [GA:0]   gnt_count;

  logic [OW-1:0] out_mem [OUT_DEPTH];
  logic [OA-1:0] out_wp;
  logic [OA-1:0] out_rp;
  logic [OA:0]   out_count;
  logic [OW-1:0] last_q;

  logic          gnt_head;
  logic          room;
  logic          sel0;
  logic          sel1;
  logic          gnt_push;
  logic          xfer;
  logic          out_pop;
  logic [OW-1:0] push_data;

  assign gnt_head = gnt_mem[gnt_rp];
  assign room     = out_count < OFULL;
  assign sel0     = (gnt_count != '0) & ~gnt_head & room;
  assign sel1     = (gnt_count != '0) & gnt_head & room;

  assign bus.win_ready = gnt_count < GFULL;
  assign bus.in0_ready = sel0;
  assign bus.in1_ready = sel1;

  assign gnt_push = bus.win_valid & bus.win_ready;
  assign xfer     = (sel0 & bus.in0_valid) | (sel1 & bus.in1_valid);
  assign out_pop  = bus.out_valid & bus.out_ready;

`ifdef WINNER_MERGE_SRC_TAG_EN
  assign push_data = {gnt_head, gnt_head ? bus.in1_data : bus.in0_data};
`else
  assign push_data = gnt_head ? bus.in1_data : bus.in0_data;
`endif

  // Empty FIFO shows the last popped word rather than a stale slot.
  assign bus.out_valid = out_count != '0;
  assign bus.out_data  = bus.out_valid ? out_mem[out_rp] : last_q;
  assign bus.idle      = (gnt_count == '0) & (out_count == '0);

  always_ff @(posedge clk) begin
    if (gnt_push) gnt_mem[gnt_wp] <= bus.win_id;
    if (xfer) out_mem[out_wp] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_wp    <= '0;
      gnt_rp    <= '0;
      gnt_count <= '0;
    end else begin
      if (gnt_push) gnt_wp <= gnt_wp + GA'(1);
      if (xfer) gnt_rp <= gnt_rp + GA'(1);
      unique case ({gnt_push, xfer})
        2'b10:   gnt_count <= gnt_count + (GA+1)'(1);
        2'b01:   gnt_count <= gnt_count - (GA+1)'(1);
        default: gnt_count <= gnt_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_wp    <= '0;
      out_rp    <= '0;
      out_count <= '0;
      last_q    <= '0;
    end else begin
      if (xfer) out_wp <= out_wp + OA'(1);
      if (out_pop) begin
        out_rp <= out_rp + OA'(1);
        last_q <= out_mem[out_rp];
      end
      unique case ({xfer, out_pop})
        2'b10:   out_count <= out_count + (OA+1)'(1);
        2'b01:   out_count <= out_count - (OA+1)'(1);
        default: out_count <= out_count;
      endcase
    end
  end
endmodule

// File: tb/tb_winner_merge_2to1.sv
// Directed bench for winner_merge_2to1: queue-fed sources, expected-output scoreboard.
// Define WINNER_MERGE_SRC_TAG_EN to also exercise the source tag bit.
module tb_winner_merge_2to1;
  localparam int W = 33;
`ifdef WINNER_MERGE_SRC_TAG_EN
  localparam int OW = W + 1;
`else
  localparam int OW = W;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  winner_merge_2to1_if #(.WIDTH(W)) bus ();

  winner_merge_2to1 #(
    .WIDTH(W),
    .GNT_DEPTH(2),
    .OUT_DEPTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic          gq [$];
  logic [W-1:0]  s0 [$];
  logic [W-1:0]  s1 [$];
  logic [OW-1:0] eq [$];
  logic          hw, h0, h1, ho;
  logic          en1, ordy;
  int            npop;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive just after the rising edge, sample and score at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (hw) void'(gq.pop_front());
    if (h0) void'(s0.pop_front());
    if (h1) void'(s1.pop_front());
    bus.win_valid = gq.size() > 0;
    bus.win_id    = (gq.size() > 0) ? gq[0] : 1'b0;
    bus.in0_valid = s0.size() > 0;
    bus.in0_data  = (s0.size() > 0) ? s0[0] : '0;
    bus.in1_valid = en1 && (s1.size() > 0);
    bus.in1_data  = (s1.size() > 0) ? s1[0] : '0;
    bus.out_ready = ordy;
    @(negedge clk);
    hw = bus.win_valid & bus.win_ready;
    h0 = bus.in0_valid & bus.in0_ready;
    h1 = bus.in1_valid & bus.in1_ready;
    ho = bus.out_valid & bus.out_ready;
    if (ho) begin
      npop++;
      if (eq.size() == 0) check("extra_out", 64'(eq.size()), 64'd1);
      else check("out_data", 64'(bus.out_data), 64'(eq.pop_front()));
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (eq.size() > 0 && n < 60) begin
      step();
      n++;
    end
    check(tag, 64'(eq.size()), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_win_ready"}, 64'(bus.win_ready), 64'd1);
    check({tag, "_in0_ready"}, 64'(bus.in0_ready), 64'd0);
    check({tag, "_in1_ready"}, 64'(bus.in1_ready), 64'd0);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
    check({tag, "_idle"}, 64'(bus.idle), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    bus.win_valid = 1'b0;
    bus.win_id    = 1'b0;
    bus.in0_valid = 1'b0;
    bus.in0_data  = '0;
    bus.in1_valid = 1'b0;
    bus.in1_data  = '0;
    bus.out_ready = 1'b0;
    {hw, h0, h1, ho} = 4'b0;
    en1  = 1'b1;
    ordy = 1'b1;
    npop = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    step();
    check_reset_vals("post_rst");

    // Alternating grants, 2-cycle grant-to-out_valid latency
    gq = '{1'b0, 1'b1, 1'b0, 1'b1};
    s0 = '{33'h11, 33'h33};
    s1 = '{33'h22, 33'h44};
    eq = '{OW'(33'h11), OW'(33'h22), OW'(33'h33), OW'(33'h44)};
    step();
    check("alt_lat0", 64'(bus.out_valid), 64'd0);
    step();
    check("alt_lat1", 64'(bus.out_valid), 64'd0);
    check("alt_in0_ready", 64'(bus.in0_ready), 64'd1);
    step();
    check("alt_lat2", 64'(bus.out_valid), 64'd1);
    drain("alt_drain");
    step();
    check("alt_idle", 64'(bus.idle), 64'd1);

    // Channel 1 grant with no data blocks the channel 0 grant behind it
    en1 = 1'b0;
    gq = '{1'b1, 1'b0};
    s1 = '{33'h0AA};
    s0 = '{33'h0BB};
    eq = '{OW'(33'h0AA), OW'(33'h0BB)};
    repeat (5) begin
      step();
      check("stall_in0_ready", 64'(bus.in0_ready), 64'd0);
      check("stall_out_valid", 64'(bus.out_valid), 64'd0);
    end
    check("stall_in1_ready", 64'(bus.in1_ready), 64'd1);
    en1 = 1'b1;
    drain("stall_drain");
    step();
    check("stall_idle", 64'(bus.idle), 64'd1);

    // Backpressure fills both FIFOs, then drains at one per cycle
    ordy = 1'b0;
    gq = '{1'b0, 1'b0, 1'b0, 1'b0};
    s0 = '{33'h0A1, 33'h0A2, 33'h0A3, 33'h0A4};
    eq = '{OW'(33'h0A1), OW'(33'h0A2), OW'(33'h0A3), OW'(33'h0A4)};
    repeat (8) step();
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    check("bp_head", 64'(bus.out_data), 64'h0A1);
    check("bp_win_ready", 64'(bus.win_ready), 64'd0);
    check("bp_in0_ready", 64'(bus.in0_ready), 64'd0);
    check("bp_idle", 64'(bus.idle), 64'd0);
    ordy = 1'b1;
    npop = 0;
    repeat (4) step();
    check("bp_tput", 64'(npop), 64'd4);
    check("bp_left", 64'(eq.size()), 64'd0);
    step();
    check("bp_idle_end", 64'(bus.idle), 64'd1);

    // Reset with two grants and one packet buffered
    ordy = 1'b0;
    en1  = 1'b0;
    gq = '{1'b0, 1'b1, 1'b1};
    s0 = '{33'h0C1};
    s1 = '{33'h0C2};
    repeat (6) step();
    check("mid_idle", 64'(bus.idle), 64'd0);
    check("mid_out_valid", 64'(bus.out_valid), 64'd1);
    check("mid_win_ready", 64'(bus.win_ready), 64'd0);
    reset = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    gq.delete();
    s0.delete();
    s1.delete();
    eq.delete();
    {hw, h0, h1, ho} = 4'b0;
    repeat (2) step();
    reset = 1'b0;
    ordy = 1'b1;
    en1  = 1'b1;
    repeat (4) step();
    check("mid_after_valid", 64'(bus.out_valid), 64'd0);
    check("mid_after_idle", 64'(bus.idle), 64'd1);

`ifdef WINNER_MERGE_SRC_TAG_EN
    gq = '{1'b1, 1'b0};
    s1 = '{33'h5};
    s0 = '{33'h6};
    eq = '{{1'b1, 33'h5}, {1'b0, 33'h6}};
    drain("tag_drain");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
